// File: rtl/pack_stream_pkg.sv
// Shared definitions for the streaming element packer: index-width helper,
// column index type and packed word width.
package pack_stream_pkg;

    localparam int DEF_BIT_WIDTH = 4;
    localparam int DEF_COLS      = 8;

    // Index width with a floor of one bit so a single-column build still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int word_w(input int bit_width, input int cols);
        return bit_width * cols;
    endfunction

    localparam int PACK_WIDTH = DEF_COLS * DEF_BIT_WIDTH;

    typedef logic [idx_w(DEF_COLS)-1:0] col_idx_t;
    typedef logic [PACK_WIDTH-1:0]      pack_word_t;

endpackage

// File: rtl/pack_col_counter.sv
// Column index for the packer: advances on every accepted element, returns to
// zero on a closing element or after the last column.
module pack_col_counter
    import pack_stream_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int CW   = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          close,
    output logic [CW-1:0] col
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
        end else if (advance) begin
            if (close || (col == CW'(COLS - 1)))
                col <= '0;
            else
                col <= col + CW'(1);
        end
    end

endmodule

// File: rtl/pack_stream_to_1d_array.sv
// Streaming packer: gathers COLS elements of BIT_WIDTH bits into one flat word
// (column 0 in the LSBs). Define PACK_LAST_EN to add in_last / out_count.
module pack_stream_to_1d_array
    import pack_stream_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int COLS      = DEF_COLS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BIT_WIDTH-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef PACK_LAST_EN
    input  logic                          in_last,
    output logic [$clog2(COLS+1)-1:0]     out_count,
`endif
    output logic [COLS*BIT_WIDTH-1:0]     out,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int PW = word_w(BIT_WIDTH, COLS);
    localparam int CW = idx_w(COLS);

    logic [CW-1:0] col;
    logic          closing;
    logic          in_fire;
    logic          out_fire;
    logic [PW-1:0] load_word;

`ifdef PACK_LAST_EN
    localparam int NW = $clog2(COLS + 1);
    assign closing = (col == CW'(COLS - 1)) || in_last;
`else
    assign closing = (col == CW'(COLS - 1));
`endif

    // Only a closing element needs the output register; partial elements never stall.
    assign in_ready = !closing || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    pack_col_counter #(
        .COLS (COLS),
        .CW   (CW)
    ) u_col_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (in_fire),
        .close   (closing),
        .col     (col)
    );

    generate
        if (COLS > 1) begin : g_acc
            logic [(COLS-1)*BIT_WIDTH-1:0] acc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (in_fire) begin
                    if (closing)
                        acc <= '0;
                    else
                        acc[int'(col)*BIT_WIDTH +: BIT_WIDTH] <= in_data;
                end
            end

            // Unfilled slots of acc are zero, so an early close leaves upper columns zero.
            // NOTE: every variable in a combinational block gets a default first, so
            // no path through the block can leave it unassigned and infer a latch.
            always_comb begin
                load_word = '0;
                load_word[(COLS-1)*BIT_WIDTH-1:0] = acc;
                load_word[int'(col)*BIT_WIDTH +: BIT_WIDTH] = in_data;
            end
        end else begin : g_no_acc
            assign load_word = in_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (in_fire && closing) begin
            out       <= load_word;
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PACK_LAST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_count <= '0;
        else if (in_fire && closing)
            out_count <= NW'(col) + NW'(1);
    end
`endif

endmodule

// File: tb/tb_pack_stream_to_1d_array.sv
// Self-checking bench for pack_stream_to_1d_array: 4x8 instance driven from a
// vector table plus hand sequences, and a COLS=1 instance.
module tb_pack_stream_to_1d_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
`ifdef PACK_LAST_EN
    logic        in_last;
    logic [3:0]  out_count;
    logic        c1_in_last;
    logic [0:0]  c1_out_count;
`endif

    logic [7:0]  c1_in_data;
    logic        c1_in_valid;
    logic        c1_in_ready;
    logic [7:0]  c1_out;
    logic        c1_out_valid;
    logic        c1_out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic [3:0]  d;
        logic        last;
        logic        ordy;
        logic        irdy;
        logic        ovld;
        logic [31:0] word;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pack_stream_to_1d_array #(.BIT_WIDTH(4), .COLS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef PACK_LAST_EN
        .in_last   (in_last),
        .out_count (out_count),
`endif
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    pack_stream_to_1d_array #(.BIT_WIDTH(8), .COLS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (c1_in_data),
        .in_valid  (c1_in_valid),
        .in_ready  (c1_in_ready),
`ifdef PACK_LAST_EN
        .in_last   (c1_in_last),
        .out_count (c1_out_count),
`endif
        .out       (c1_out),
        .out_valid (c1_out_valid),
        .out_ready (c1_out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [3:0] d, input logic last,
                                input logic ordy, input logic irdy, input logic ovld,
                                input logic [31:0] word, input logic [3:0] cnt);
        vec_t v;
        v.vld = vld; v.d = d; v.last = last; v.ordy = ordy;
        v.irdy = irdy; v.ovld = ovld; v.word = word; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge, check on the falling edge.
    task automatic step(input string name, input vec_t v);
        @(posedge clk);
        #1;
        in_valid  = v.vld;
        in_data   = v.d;
        out_ready = v.ordy;
`ifdef PACK_LAST_EN
        in_last   = v.last;
`endif
        @(negedge clk);
        check({name, " in_ready"}, 32'(in_ready), 32'(v.irdy));
        check({name, " out_valid"}, 32'(out_valid), 32'(v.ovld));
        if (v.ovld) begin
            check({name, " out"}, out, v.word);
`ifdef PACK_LAST_EN
            check({name, " out_count"}, 32'(out_count), 32'(v.cnt));
`endif
        end
    endtask

    task automatic step1(input string name, input logic vld, input logic [7:0] d,
                         input logic ordy, input logic irdy, input logic ovld,
                         input logic [7:0] word);
        @(posedge clk);
        #1;
        c1_in_valid  = vld;
        c1_in_data   = d;
        c1_out_ready = ordy;
        @(negedge clk);
        check({name, " in_ready"}, 32'(c1_in_ready), 32'(irdy));
        check({name, " out_valid"}, 32'(c1_out_valid), 32'(ovld));
        if (ovld)
            check({name, " out"}, 32'(c1_out), 32'(word));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        c1_in_valid = 1'b0; c1_in_data = '0; c1_out_ready = 1'b0;
`ifdef PACK_LAST_EN
        in_last = 1'b0; c1_in_last = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out", out, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
        check("reset c1 out", 32'(c1_out), 32'h0);
        check("reset c1 out_valid", 32'(c1_out_valid), 32'h0);
        check("reset c1 in_ready", 32'(c1_in_ready), 32'h1);
`ifdef PACK_LAST_EN
        check("reset out_count", 32'(out_count), 32'h0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back 1..8 with consumer always ready
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'd8));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));

        // Two words with the consumer stalled; the 16th element waits for out to drain
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'd0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b1, 32'h87654321, 4'd8));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h87654321, 4'd8));
        vecs.push_back(mk(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'd8));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'd8));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));

        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i]);

        // Reset after three accepted elements: partial word must vanish
        for (int i = 0; i < 3; i++)
            step($sformatf("pre_rst%0d", i), mk(1'b1, 4'(i + 5), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid reset out", out, 32'h0);
        check("mid reset out_valid", 32'(out_valid), 32'h0);
        check("mid reset in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++)
            step($sformatf("post_rst%0d", i), mk(1'b1, 4'(4'hA + i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
        step("post_rst word", mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10FEDCBA, 4'd8));
        step("post_rst idle", mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));

        // Single-column instance: every element is a word
        step1("c1 s0", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00);
        step1("c1 s1", 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'h5A);
        step1("c1 s2", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3);
        step1("c1 s3", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00);
        step1("c1 stall", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11);
        step1("c1 drain", 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11);
        step1("c1 s6", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22);
        step1("c1 s7", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);

`ifdef PACK_LAST_EN
        // Early close after three elements, then a full word
        step("last a0", mk(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
        step("last a1", mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
        step("last a2", mk(1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
        for (int i = 0; i < 8; i++)
            step($sformatf("last full%0d", i),
                 mk(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b1, (i == 0), 32'h00000321, 4'd3));
        step("last full word", mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'd8));
        step("last full idle", mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));

        // One-element word stalled two cycles; next element lands in column 0
        step("last b0", mk(1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'd0));
        step("last b1", mk(1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000007, 4'd1));
        step("last b2", mk(1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000007, 4'd1));
        step("last b3", mk(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000007, 4'd1));
        step("last b4", mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000059, 4'd2));
        step("last b5", mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'd0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pack_stream_to_1d_array.md
# pack_stream_to_1d_array

Streaming packer: accepts one BIT_WIDTH element per cycle over a valid/ready handshake and assembles COLS elements into a single flat COLS*BIT_WIDTH word with column 0 in the LSBs. It sits between element-serial producers (per-sample pipelines, memory readers) and wide consumers that take a whole packed row per transfer. Both sides are backpressured, and the block sustains one element per cycle when the consumer does not stall.

## Interface
- BIT_WIDTH, 4, width of one element (≥1)
- COLS, 8, elements per packed word (≥1)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  BIT_WIDTH  element to pack
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- in_last  input  1  closes the current word early (PACK_LAST_EN only)
- out  output  COLS*BIT_WIDTH  packed word; column i at out[(i+1)*BIT_WIDTH-1 -: BIT_WIDTH]
- out_valid  output  1  out holds a complete word
- out_ready  input  1  consumer accepts out this cycle
- out_count  output  $clog2(COLS+1)  number of filled columns in out (PACK_LAST_EN only)

## Operation
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready.
- Accumulator acc (COLS-1 element slots) and column index col (0..COLS-1). An accepted element is written to column col.
- Element accepted with col < COLS-1 (and not closing): stored in acc, col increments.
- Closing element (col == COLS-1, or in_last under macro): {incoming element, acc} loads into out in the same edge, out_valid←1, acc cleared to 0, col←0.
- in_ready = (closing condition false) || !out_valid || out_ready. in_ready depends combinationally on out_ready and on in_last; there is no combinational path from in_valid to in_ready.
- Non-closing elements are always accepted, even while out is stalled.
- Output transfer without a simultaneous load: out_valid←0. out retains its value, and its contents are don't-care while out_valid=0.
- Simultaneous output transfer and load: new word replaces old, out_valid stays 1.
- COLS=1: every accepted element is a closing element, acc is absent, and out = in_data registered.
- Reset mid-word: partial acc contents are discarded, and any pending out word is dropped.

## Timing
- Reset values: out=0, out_valid=0, col=0, acc=0, out_count=0, in_ready=1.
- Latency: a word is visible on out, with out_valid=1, in the cycle after its closing element is accepted.
- Throughput: 1 element/cycle, i.e. one word every COLS cycles, with out_ready held high.
- Stall: if the closing element arrives while out_valid=1 and out_ready=0, in_ready=0 and the element is held by the producer until out drains.
- out and out_valid are stable while out_valid=1 and out_ready=0.

## Configuration
- PACK_LAST_EN defined: in_last and out_count ports exist.
  - An accepted element with in_last=1 closes the word at any col.
  - Unfilled columns of out are 0.
  - out_count = col+1 of the closing element, or COLS for a full word.
  - in_last at col == COLS-1 is equivalent to a normal close.
- PACK_LAST_EN undefined: in_last and out_count ports are absent, and words close only at COLS elements.

## Structure
- Shared package pack_stream_pkg:
  - index-width helper function (clog2 with minimum 1)
  - typedef for column index
  - localparam for packed word width (COLS*BIT_WIDTH)
- One sub-module, pack_col_counter: col register with increment, clear-on-close and wrap. The handshake and data path stay in the top.

## Test plan
- BIT_WIDTH=4, COLS=8, out_ready=1, feed 1..8 back-to-back → out=32'h87654321 one cycle after the 8th accept, out_valid high 1 cycle; in_ready never low.
- Same stream twice with out_ready=0 until cycle 20:
  - first word held stable from cycle 9.
  - in_ready low only while presenting the 16th element.
  - after out_ready rises, second word 32'h87654321 follows the first with no loss.
- rst_n low after 3 elements accepted, then 8 fresh elements A..F,0,1 → out=32'h10FEDCBA; the earlier partial data never appears.
- COLS=1, BIT_WIDTH=8, elements 8'h5A, 8'hC3 with out_ready=1 → out=5A then C3 on consecutive cycles.
- PACK_LAST_EN, elements 1,2,3 with in_last on 3 → out=32'h00000321, out_count=3; next full word unaffected, out_count=8.
- PACK_LAST_EN, single element 7 with in_last, out stalled 2 cycles → out=32'h00000007, out_count=1 held stable; following element accepted during the stall goes to column 0 of the next word.
